// File: rtl/wb_pio_master_if.sv
// Command/response stream and Wishbone classic bus signals of the PIO bus initiator.
// The master modport is the initiator's view. The slave modport is the environment's view.
interface wb_pio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  logic        busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i,
    input  busy
  );
endinterface

// File: rtl/wb_pio_master.sv
// Wishbone classic initiator: queues valid/ready commands and issues one bus cycle at a time.
// Each command returns exactly one response, and a missing ack is reported as a timeout.
module wb_pio_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  wb_pio_master_if.master bus
);
  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0]     TMR_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   tmr_q, tmr_d;

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;

  cmd_t          fifo_q [FIFO_DEPTH];
  cmd_t          wr_entry;
  cmd_t          head;
  logic          push;
  logic          pop;
  logic          start;
  logic          timed_out;

  // Ready depends on occupancy only, so a full FIFO never accepts a command, even while popping.
  assign bus.cmd_ready = wb_rst_ni && (count_q < CNT_FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign wr_entry      = {bus.cmd_we, bus.cmd_adr, bus.cmd_dat, bus.cmd_sel};
  assign head          = fifo_q[rd_ptr_q];

  assign start     = (state_q == S_IDLE) && (count_q != '0) && !rsp_valid_q;
  assign pop       = start;
  assign timed_out = (tmr_q == TMR_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmr_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmr_q       <= tmr_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUS;
      S_BUS:   if (bus.wbm_ack_i || timed_out) state_d = S_RSP;
      S_RSP:   if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmr_d       = tmr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cyc_d = 1'b1;
          we_d  = head.we;
          sel_d = head.sel;
          adr_d = head.adr;
          dat_d = head.we ? head.dat : '0;
          tmr_d = '0;
        end
      end
      S_BUS: begin
        // An ack on the final timeout cycle still counts as a normal completion.
        if (bus.wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
          rsp_err_d   = 1'b0;
        end else if (timed_out) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;

  assign bus.busy = (count_q != '0) || (state_q != S_IDLE) || rsp_valid_q;
endmodule

// File: tb/tb_wb_pio_master.sv
// Scoreboard bench for wb_pio_master: an address-driven slave model plus queues of expected
// bus cycles and responses.
module tb_wb_pio_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_pio_master_if ifc ();

  wb_pio_master #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (ifc)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    int          dur;
  } bus_exp_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        err;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int total      = 0;
  int bad        = 0;
  int bus_cycles = 0;
  int n_rsp      = 0;
  int rdy_mode   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave ack delay comes from address bits [11:8]: code c acks c+1 cycles after stb, 0xF never acks.
  function automatic int ack_delay(input logic [31:0] adr);
    if (adr[11:8] == 4'hF) return 0;
    return int'(adr[11:8]) + 1;
  endfunction

  function automatic logic [31:0] slave_rdata(input logic [31:0] adr);
    if (adr == 32'h3000_0000) return 32'hCAFE_F00D;
    return {~adr[15:0], adr[15:0]};
  endfunction

  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bus_exp_t b;
    rsp_exp_t r;
    int       d;
    logic     tmo;
    logic     rdy;
    int       guard;
    d        = ack_delay(adr);
    tmo      = (d == 0) || (d > TMO);
    b.we     = we;
    b.adr    = adr;
    b.dat    = we ? dat : 32'h0;
    b.sel    = sel;
    b.delay  = d;
    b.dur    = tmo ? TMO : d;
    r.adr    = adr;
    r.err    = tmo;
    r.dat    = (tmo || we) ? 32'h0 : slave_rdata(adr);
    bus_q.push_back(b);
    rsp_q.push_back(r);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_we    = we;
    ifc.cmd_adr   = adr;
    ifc.cmd_dat   = dat;
    ifc.cmd_sel   = sel;
    guard = 0;
    forever begin
      @(negedge clk);
      rdy = ifc.cmd_ready;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 500) begin
        check_val("push_wait", 64'(rdy), 64'(1));
        break;
      end
    end
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int   n;
    logic done;
    done = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!ifc.busy && bus_q.size() == 0 && rsp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_val(tag, 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ifc.rsp_ready = 1'b0;
        1:       ifc.rsp_ready = 1'b1;
        default: ifc.rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Slave model: checks each new bus cycle against the expected queue and acks after the address-coded delay.
  initial begin
    int       cnt;
    int       low;
    logic     prev;
    bus_exp_t cur;
    cnt       = 0;
    low       = 1;
    prev      = 1'b0;
    cur.we    = 1'b0;
    cur.adr   = 32'h0;
    cur.dat   = 32'h0;
    cur.sel   = 4'h0;
    cur.delay = 0;
    cur.dur   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ifc.wbm_ack_i = 1'b0;
        cnt  = 0;
        low  = 1;
        prev = 1'b0;
      end else begin
        if (ifc.wbm_cyc_o) begin
          if (!prev) begin
            bus_cycles++;
            check_val("cyc_gap", 64'(low >= 1), 64'(1));
            check_val("stb", 64'(ifc.wbm_stb_o), 64'(1));
            if (bus_q.size() == 0) begin
              check_val("bus_unexpected", 64'(bus_q.size()), 64'(1));
              cur.adr   = ifc.wbm_adr_o;
              cur.we    = ifc.wbm_we_o;
              cur.delay = 1;
              cur.dur   = 1;
            end else begin
              cur = bus_q.pop_front();
              check_val("bus_we", 64'(ifc.wbm_we_o), 64'(cur.we));
              check_val("bus_adr", 64'(ifc.wbm_adr_o), 64'(cur.adr));
              check_val("bus_dat", 64'(ifc.wbm_dat_o), 64'(cur.dat));
              check_val("bus_sel", 64'(ifc.wbm_sel_o), 64'(cur.sel));
            end
            cnt = 0;
          end else begin
            check_val("adr_hold", 64'(ifc.wbm_adr_o), 64'(cur.adr));
          end
          low = 0;
          cnt++;
          if (cnt == cur.delay) begin
            ifc.wbm_ack_i = 1'b1;
            ifc.wbm_dat_i = cur.we ? 32'hDEAD_BEEF : slave_rdata(cur.adr);
          end else begin
            ifc.wbm_ack_i = 1'b0;
            ifc.wbm_dat_i = 32'hDEAD_BEEF;
          end
        end else begin
          if (prev) check_val("cyc_len", 64'(cnt), 64'(cur.dur));
          ifc.wbm_ack_i = 1'b0;
          low++;
        end
        prev = ifc.wbm_cyc_o;
      end
    end
  end

  // Response monitor: compares each new response once, and re-arms after the cycle in which it is consumed.
  initial begin
    logic     seen;
    rsp_exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (ifc.rsp_valid) begin
        if (!seen) begin
          n_rsp++;
          if (rsp_q.size() == 0) begin
            check_val("rsp_unexpected", 64'(rsp_q.size()), 64'(1));
          end else begin
            e = rsp_q.pop_front();
            check_val("rsp_dat", 64'(ifc.rsp_dat), 64'(e.dat));
            check_val("rsp_err", 64'(ifc.rsp_err), 64'(e.err));
            $display("rsp %0d adr=%h dat=%h err=%0d", n_rsp, e.adr, ifc.rsp_dat, ifc.rsp_err);
          end
          seen = 1'b1;
        end
        if (ifc.rsp_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base;
    logic [3:0]  codes [11];
    logic [31:0] adr;
    int          idx;
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};
    ifc.cmd_valid = 1'b0;
    ifc.cmd_we    = 1'b0;
    ifc.cmd_adr   = 32'h0;
    ifc.cmd_dat   = 32'h0;
    ifc.cmd_sel   = 4'h0;
    ifc.rsp_ready = 1'b0;
    ifc.wbm_ack_i = 1'b0;
    ifc.wbm_dat_i = 32'h0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cyc", 64'(ifc.wbm_cyc_o), 64'(0));
    check_val("rst_stb", 64'(ifc.wbm_stb_o), 64'(0));
    check_val("rst_we", 64'(ifc.wbm_we_o), 64'(0));
    check_val("rst_sel", 64'(ifc.wbm_sel_o), 64'(0));
    check_val("rst_adr", 64'(ifc.wbm_adr_o), 64'(0));
    check_val("rst_dat", 64'(ifc.wbm_dat_o), 64'(0));
    check_val("rst_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
    check_val("rst_rsp_dat", 64'(ifc.rsp_dat), 64'(0));
    check_val("rst_rsp_err", 64'(ifc.rsp_err), 64'(0));
    check_val("rst_busy", 64'(ifc.busy), 64'(0));
    check_val("rst_cmd_ready", 64'(ifc.cmd_ready), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_cmd_ready", 64'(ifc.cmd_ready), 64'(1));

    // Single write to an empty block, with exact cycle timing
    rdy_mode = 1;
    @(posedge clk);
    #1;
    push_cmd(1'b1, 32'h3000_0004, 32'h0000_1234, 4'hF);
    @(posedge clk);
    #1;
    check_val("t1_cyc", 64'(ifc.wbm_cyc_o), 64'(1));
    check_val("t1_stb", 64'(ifc.wbm_stb_o), 64'(1));
    check_val("t1_adr", 64'(ifc.wbm_adr_o), 64'(32'h3000_0004));
    check_val("t1_dat", 64'(ifc.wbm_dat_o), 64'(32'h0000_1234));
    @(posedge clk);
    #1;
    check_val("t1_rsp_valid", 64'(ifc.rsp_valid), 64'(1));
    @(posedge clk);
    #1;
    check_val("t1_rsp_gone", 64'(ifc.rsp_valid), 64'(0));
    check_val("t1_busy", 64'(ifc.busy), 64'(0));

    // Read: write data must be forced to zero on the bus
    push_cmd(1'b0, 32'h3000_0000, 32'h5555_AAAA, 4'h3);
    wait_drain("t2_drain");

    // Queue and backpressure: response held, FIFO fills
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base = bus_cycles;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'(i), 32'h3000_0020 | (32'(i) << 8) | (32'(i) << 2),
               32'h1000_0000 + 32'(i), 4'hF ^ 4'(i));
    end
    repeat (6) @(posedge clk);
    #1;
    check_val("t3_cmd_ready_full", 64'(ifc.cmd_ready), 64'(0));
    check_val("t3_one_cycle", 64'(bus_cycles - base), 64'(1));
    check_val("t3_rsp_held", 64'(ifc.rsp_valid), 64'(1));
    check_val("t3_busy", 64'(ifc.busy), 64'(1));
    rdy_mode = 1;
    push_cmd(1'b0, 32'h3000_0534, 32'h1000_0005, 4'hA);
    wait_drain("t3_drain");
    check_val("t3_cycles", 64'(bus_cycles - base), 64'(6));

    // Timeout followed by a normal queued read
    push_cmd(1'b0, 32'h3000_0F00, 32'h0, 4'hF);
    push_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    wait_drain("t4_drain");

    // Ack on the last allowed cycle, ack one cycle too late, ack one cycle early
    push_cmd(1'b0, 32'h3000_0700, 32'h0, 4'hF);
    push_cmd(1'b0, 32'h3000_0800, 32'h0, 4'hF);
    push_cmd(1'b1, 32'h3000_0600, 32'h7777_0000, 4'h1);
    wait_drain("t5_drain");

    // Mixed traffic with random response backpressure
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(0, 10);
      adr = 32'h3000_0000 | {20'h0, codes[idx], 8'h00} | (32'($urandom_range(0, 63)) << 2);
      push_cmd(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(1, 15)));
    end
    wait_drain("rand_drain");

    // Reset mid-cycle with three commands queued
    rdy_mode = 1;
    @(posedge clk);
    #1;
    base = bus_cycles;
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b1, 32'h3000_0F00 + 32'(i * 4), 32'hAB00_0000 + 32'(i), 4'hF);
    end
    check_val("t6_cyc_before", 64'(ifc.wbm_cyc_o), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("t6_cyc", 64'(ifc.wbm_cyc_o), 64'(0));
    check_val("t6_stb", 64'(ifc.wbm_stb_o), 64'(0));
    check_val("t6_rsp_valid", 64'(ifc.rsp_valid), 64'(0));
    check_val("t6_busy", 64'(ifc.busy), 64'(0));
    check_val("t6_cmd_ready_rst", 64'(ifc.cmd_ready), 64'(0));
    bus_q.delete();
    rsp_q.delete();
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("t6_no_cycle", 64'(bus_cycles - base), 64'(1));
    check_val("t6_cmd_ready", 64'(ifc.cmd_ready), 64'(1));
    check_val("t6_busy_after", 64'(ifc.busy), 64'(0));
    check_val("t6_cyc_after", 64'(ifc.wbm_cyc_o), 64'(0));

    // Block still works after the mid-cycle reset
    push_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wait_drain("t6_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
